// File: rtl/cpu_pkg.sv
// Shared opcode/state encodings, instruction field positions and immediate helpers
// for the 16-bit fetch/decode/execute sequencer.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_ADDI = 4'h8,
        OP_BEQZ = 4'h9,
        OP_JR   = 4'hA,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_PCUP   = 3'd5,
        ST_HALTED = 3'd6
    } state_e;

    localparam int unsigned OP_HI  = 15;
    localparam int unsigned OP_LO  = 12;
    localparam int unsigned RD_HI  = 11;
    localparam int unsigned RD_LO  = 8;
    localparam int unsigned RS1_HI = 7;
    localparam int unsigned RS1_LO = 4;
    localparam int unsigned RS2_HI = 3;
    localparam int unsigned RS2_LO = 0;
    localparam int unsigned OFF_HI = 7;
    localparam int unsigned OFF_LO = 0;

    localparam logic [3:0] PC_REG_DEFAULT = 4'd15;

    function automatic logic [15:0] sext4(input logic [3:0] v);
        return {{12{v[3]}}, v};
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/alu16.sv
// Combinational 16-bit ALU for opcodes ADD..ADDI; all results wrap mod 2^16,
// anything else yields zero.
module alu16
    import cpu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = a << b[3:0];
            OP_SHR:  result = a >> b[3:0];
            OP_ADDI: result = a + b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle fetch/decode/execute sequencer driving the register file read,
// GPR write and PC write ports, with an imem req/ack fetch handshake.
module ctrl_seq
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  PC_REG   = PC_REG_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_en,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [3:0]  out1_addr,
    output logic [3:0]  out2_addr,
    output logic        out1_en,
    output logic        out2_en,
    input  logic [15:0] rf_out1,
    input  logic [15:0] rf_out2,
    output logic [15:0] w_data,
    output logic [3:0]  w_addr,
    output logic        w_en,
    output logic [15:0] pc_data,
    output logic [3:0]  pc_addr,
    output logic        pc_en,
    output logic        halted,
    output logic        illegal
);

    state_e      state_q;
    logic [15:0] pc_q;
    logic [15:0] ir_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] res_q;
    logic [15:0] npc_q;
    logic        illegal_q;

    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic        is_alu;
    logic        is_bad_op;
    logic [15:0] alu_res;
    logic [15:0] pc_inc;
    logic [15:0] npc;

    assign op  = ir_q[OP_HI:OP_LO];
    assign rd  = ir_q[RD_HI:RD_LO];
    assign rs1 = ir_q[RS1_HI:RS1_LO];
    assign rs2 = ir_q[RS2_HI:RS2_LO];

    assign is_alu    = (op >= OP_ADD) && (op <= OP_ADDI);
    assign is_bad_op = (op >= 4'hB) && (op <= 4'hE);

    alu16 u_alu (
        .op     (op),
        .a      (a_q),
        .b      (b_q),
        .result (alu_res)
    );

    assign pc_inc = pc_q + 16'd1;

    always_comb begin
        npc = pc_inc;
        if (op == OP_BEQZ && a_q == '0) begin
            npc = pc_inc + sext8(ir_q[OFF_HI:OFF_LO]);
        end else if (op == OP_JR) begin
            npc = a_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            npc_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run_en) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir_q    <= imem_rdata;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    a_q     <= rf_out1;
                    b_q     <= (op == OP_ADDI) ? sext4(rs2) : rf_out2;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_q <= alu_res;
                    npc_q <= npc;
                    // Writing the PC through an ALU op is rejected; the PC still advances.
                    if (op == OP_HALT) begin
                        state_q <= ST_HALTED;
                    end else if (is_bad_op || (is_alu && rd == PC_REG)) begin
                        illegal_q <= 1'b1;
                        state_q   <= ST_PCUP;
                    end else if (is_alu) begin
                        state_q <= ST_WB;
                    end else begin
                        state_q <= ST_PCUP;
                    end
                end
                ST_WB: begin
                    state_q <= ST_PCUP;
                end
                ST_PCUP: begin
                    pc_q    <= npc_q;
                    state_q <= ST_FETCH;
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = '0;
        out1_en   = 1'b0;
        out1_addr = '0;
        out2_en   = 1'b0;
        out2_addr = '0;
        w_en      = 1'b0;
        w_addr    = '0;
        w_data    = '0;
        pc_en     = 1'b0;
        pc_addr   = '0;
        pc_data   = '0;
        halted    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc_q;
            end
            ST_DECODE: begin
                if (is_alu) begin
                    out1_en   = 1'b1;
                    out1_addr = rs1;
                    out2_en   = 1'b1;
                    out2_addr = rs2;
                end else if (op == OP_BEQZ || op == OP_JR) begin
                    out1_en   = 1'b1;
                    out1_addr = rd;
                end
            end
            ST_WB: begin
                w_en   = 1'b1;
                w_addr = rd;
                w_data = res_q;
            end
            ST_PCUP: begin
                pc_en   = 1'b1;
                pc_addr = PC_REG;
                pc_data = npc_q;
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal = illegal_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: table of single-instruction vectors plus hand-written
// sequences for delayed ack, sticky illegal, PC wrap/HALT and reset during WB.
module tb_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_en;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [3:0]  out1_addr, out2_addr;
    logic        out1_en, out2_en;
    logic [15:0] rf_out1, rf_out2;
    logic [15:0] w_data;
    logic [3:0]  w_addr;
    logic        w_en;
    logic [15:0] pc_data;
    logic [3:0]  pc_addr;
    logic        pc_en;
    logic        halted;
    logic        illegal;

    logic [15:0] regs [16];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        done;
        logic        w_seen;
        logic        halt;
        logic        addr_bad;
        logic [3:0]  w_addr;
        logic [15:0] w_data;
        logic [3:0]  pc_addr;
        logic [15:0] pc_data;
        logic [15:0] first_addr;
        int          cycles;
        int          w_cycle;
        int          fetches;
    } obs_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [3:0]  ra;
        logic [15:0] va;
        logic [3:0]  rb;
        logic [15:0] vb;
        logic        ew;
        logic [3:0]  ewa;
        logic [15:0] ewd;
        logic [15:0] epc;
        logic        eill;
        int          ecyc;
    } vec_t;

    vec_t vt[17];

    assign rf_out1 = regs[out1_addr];
    assign rf_out2 = regs[out2_addr];

    always #5 clk = ~clk;

    ctrl_seq #(.RESET_PC(16'h0000), .PC_REG(4'd15)) dut (
        .clk        (clk),
        .rst        (rst),
        .run_en     (run_en),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .out1_addr  (out1_addr),
        .out2_addr  (out2_addr),
        .out1_en    (out1_en),
        .out2_en    (out2_en),
        .rf_out1    (rf_out1),
        .rf_out2    (rf_out2),
        .w_data     (w_data),
        .w_addr     (w_addr),
        .w_en       (w_en),
        .pc_data    (pc_data),
        .pc_addr    (pc_addr),
        .pc_en      (pc_en),
        .halted     (halted),
        .illegal    (illegal)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic any_out();
        return |{imem_req, imem_addr, out1_addr, out2_addr, out1_en, out2_en,
                 w_data, w_addr, w_en, pc_data, pc_addr, pc_en, halted, illegal};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        run_en     = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        for (int i = 0; i < 16; i++) regs[i] = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Steps one instruction from the cycle before FETCH; acks after 'delay' wait cycles.
    task automatic run_instr(input logic [15:0] instr, input int delay, input logic stop_w,
                             output obs_t o);
        int n;
        o.done = 1'b0; o.w_seen = 1'b0; o.halt = 1'b0; o.addr_bad = 1'b0;
        o.w_addr = '0; o.w_data = '0; o.pc_addr = '0; o.pc_data = '0; o.first_addr = '0;
        o.cycles = 0; o.w_cycle = 0; o.fetches = 0;
        n = 0;
        while (!o.done && n < 40) begin
            @(negedge clk);
            n++;
            imem_ack   = 1'b0;
            imem_rdata = '0;
            if (imem_req) begin
                o.fetches++;
                if (o.fetches == 1) o.first_addr = imem_addr;
                else if (imem_addr != o.first_addr) o.addr_bad = 1'b1;
                if (o.fetches > delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = instr;
                end
            end
            if (w_en) begin
                o.w_seen  = 1'b1;
                o.w_addr  = w_addr;
                o.w_data  = w_data;
                o.w_cycle = n;
                if (stop_w) o.done = 1'b1;
                else regs[w_addr] = w_data;
            end
            if (pc_en) begin
                o.pc_addr = pc_addr;
                o.pc_data = pc_data;
                regs[pc_addr] = pc_data;
                o.done = 1'b1;
            end
            if (halted) begin
                o.halt = 1'b1;
                o.done = 1'b1;
            end
            o.cycles = n;
        end
        chk("instr_done", 32'(o.done), 32'd1);
    endtask

    initial begin
        obs_t o;
        logic seen;
        logic held;

        rst = 1'b1; run_en = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        for (int i = 0; i < 16; i++) regs[i] = '0;

        //        pc        instr     ra    va        rb    vb        ew    ewa   ewd       epc       eill  cyc
        vt[0]  = '{16'h0000, 16'h1312, 4'd1, 16'h0005, 4'd2, 16'h0007, 1'b1, 4'd3, 16'h000C, 16'h0001, 1'b0, 5};
        vt[1]  = '{16'h0000, 16'h2312, 4'd1, 16'h0005, 4'd2, 16'h0007, 1'b1, 4'd3, 16'hFFFE, 16'h0001, 1'b0, 5};
        vt[2]  = '{16'h0000, 16'h3412, 4'd1, 16'h00F0, 4'd2, 16'h0FF0, 1'b1, 4'd4, 16'h00F0, 16'h0001, 1'b0, 5};
        vt[3]  = '{16'h0000, 16'h4512, 4'd1, 16'h00F0, 4'd2, 16'h0F00, 1'b1, 4'd5, 16'h0FF0, 16'h0001, 1'b0, 5};
        vt[4]  = '{16'h0000, 16'h5612, 4'd1, 16'hFFFF, 4'd2, 16'h0F0F, 1'b1, 4'd6, 16'hF0F0, 16'h0001, 1'b0, 5};
        vt[5]  = '{16'h0000, 16'h6712, 4'd1, 16'h8001, 4'd2, 16'h0004, 1'b1, 4'd7, 16'h0010, 16'h0001, 1'b0, 5};
        vt[6]  = '{16'h0000, 16'h7812, 4'd1, 16'h8001, 4'd2, 16'h0013, 1'b1, 4'd8, 16'h1000, 16'h0001, 1'b0, 5};
        vt[7]  = '{16'h0000, 16'h891F, 4'd1, 16'h0005, 4'd2, 16'h0000, 1'b1, 4'd9, 16'h0004, 16'h0001, 1'b0, 5};
        vt[8]  = '{16'h0000, 16'h8917, 4'd1, 16'hFFFC, 4'd2, 16'h0000, 1'b1, 4'd9, 16'h0003, 16'h0001, 1'b0, 5};
        vt[9]  = '{16'h0010, 16'h9405, 4'd4, 16'h0000, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h0016, 1'b0, 4};
        vt[10] = '{16'h0010, 16'h9405, 4'd4, 16'h0001, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h0011, 1'b0, 4};
        vt[11] = '{16'h0010, 16'h94FE, 4'd4, 16'h0000, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h000F, 1'b0, 4};
        vt[12] = '{16'h0000, 16'hA300, 4'd3, 16'h1234, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h1234, 1'b0, 4};
        vt[13] = '{16'hFFFF, 16'h0000, 4'd0, 16'h0000, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0, 4};
        vt[14] = '{16'h0000, 16'hB000, 4'd0, 16'h0000, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h0001, 1'b1, 4};
        vt[15] = '{16'h0000, 16'h1F12, 4'd1, 16'h0005, 4'd2, 16'h0007, 1'b0, 4'd0, 16'h0000, 16'h0001, 1'b1, 4};
        vt[16] = '{16'h0000, 16'hE123, 4'd0, 16'h0000, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h0001, 1'b1, 4};

        // Reset state, during and after reset
        @(negedge clk);
        #1;
        chk("reset_outputs_held", 32'(any_out()), 32'd0);
        do_reset();
        @(negedge clk);
        chk("idle_outputs", 32'(any_out()), 32'd0);

        foreach (vt[k]) begin
            do_reset();
            regs[vt[k].ra] = vt[k].va;
            regs[vt[k].rb] = vt[k].vb;
            regs[14]       = vt[k].pc;
            run_en = 1'b1;
            if (vt[k].pc != 16'h0000) run_instr(16'hAE00, 0, 1'b0, o);
            run_instr(vt[k].instr, 0, 1'b0, o);
            chk($sformatf("v%0d_fetch_addr", k), 32'(o.first_addr), 32'(vt[k].pc));
            chk($sformatf("v%0d_w_seen", k), 32'(o.w_seen), 32'(vt[k].ew));
            if (vt[k].ew) begin
                chk($sformatf("v%0d_w_addr", k), 32'(o.w_addr), 32'(vt[k].ewa));
                chk($sformatf("v%0d_w_data", k), 32'(o.w_data), 32'(vt[k].ewd));
                chk($sformatf("v%0d_w_cycle", k), 32'(o.w_cycle), 32'd4);
            end
            chk($sformatf("v%0d_pc_data", k), 32'(o.pc_data), 32'(vt[k].epc));
            chk($sformatf("v%0d_pc_addr", k), 32'(o.pc_addr), 32'd15);
            chk($sformatf("v%0d_cycles", k), 32'(o.cycles), 32'(vt[k].ecyc));
            chk($sformatf("v%0d_illegal", k), 32'(illegal), 32'(vt[k].eill));
        end

        // Ack delayed by 3 cycles: 4 FETCH cycles with a stable request, 8 cycles total
        do_reset();
        regs[1] = 16'd5; regs[2] = 16'd7;
        run_en = 1'b1;
        run_instr(16'h1312, 3, 1'b0, o);
        chk("dly_fetches", 32'(o.fetches), 32'd4);
        chk("dly_addr_stable", 32'(o.addr_bad), 32'd0);
        chk("dly_w_cycle", 32'(o.w_cycle), 32'd7);
        chk("dly_w_data", 32'(o.w_data), 32'h000C);
        chk("dly_cycles", 32'(o.cycles), 32'd8);

        // Illegal flag is sticky across a following legal instruction
        do_reset();
        run_en = 1'b1;
        run_instr(16'hB000, 0, 1'b0, o);
        chk("sticky_first", 32'(illegal), 32'd1);
        run_instr(16'h1312, 0, 1'b0, o);
        chk("sticky_after_add", 32'(illegal), 32'd1);
        chk("sticky_add_w", 32'(o.w_seen), 32'd1);
        chk("sticky_add_pc", 32'(o.pc_data), 32'h0002);

        // PC wrap on NOP at 0xFFFF, then HALT at 0x0000
        do_reset();
        regs[14] = 16'hFFFF;
        run_en = 1'b1;
        run_instr(16'hAE00, 0, 1'b0, o);
        run_instr(16'h0000, 0, 1'b0, o);
        chk("wrap_pc", 32'(o.pc_data), 32'h0000);
        run_instr(16'hF000, 0, 1'b0, o);
        chk("halt_seen", 32'(o.halt), 32'd1);
        chk("halt_addr", 32'(o.first_addr), 32'h0000);
        chk("halt_cycles", 32'(o.cycles), 32'd4);
        seen = 1'b0; held = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | imem_req | pc_en | w_en;
            held = held & halted;
        end
        chk("halt_no_req", 32'(seen), 32'd0);
        chk("halt_persist", 32'(held), 32'd1);

        // Reset asserted during WB, then a stale ack while idle
        do_reset();
        regs[1] = 16'd5; regs[2] = 16'd7; regs[14] = 16'h0010;
        run_en = 1'b1;
        run_instr(16'hAE00, 0, 1'b0, o);
        run_instr(16'h1312, 0, 1'b1, o);
        chk("wb_reached", 32'(o.w_seen), 32'd1);
        chk("wb_addr_before_rst", 32'(o.first_addr), 32'h0010);
        rst = 1'b1;
        #1;
        chk("rst_w_en_drop", 32'(w_en), 32'd0);
        chk("rst_all_zero", 32'(any_out()), 32'd0);
        @(negedge clk);
        rst = 1'b0; run_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1; imem_rdata = 16'h1312;
            @(negedge clk);
            seen = seen | any_out();
        end
        imem_ack = 1'b0; imem_rdata = '0;
        chk("stale_ack_ignored", 32'(seen), 32'd0);
        run_en = 1'b1;
        run_instr(16'h1312, 0, 1'b0, o);
        chk("post_rst_fetch_addr", 32'(o.first_addr), 32'h0000);
        chk("post_rst_w_data", 32'(o.w_data), 32'h000C);
        chk("post_rst_pc", 32'(o.pc_data), 32'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
Multi-cycle fetch/decode/execute sequencer for the 16-bit core. Sits directly upstream of the 16x16 register file and drives its read ports (out1/out2 addr+en), its write port (w_*) and its PC port (pc_*). Fetches from instruction memory over a req/ack handshake. Contains an inline ALU. The PC lives in register PC_REG and is mirrored in an internal pc_q.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
PC_REG, 4'd15, register-file index that holds the PC.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
run_en  in  1  leave IDLE and start fetching
imem_req  out  1  fetch request, held until ack
imem_addr  out  16  fetch address (= pc_q)
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  16  instruction word
out1_addr / out2_addr  out  4  rf read addresses
out1_en / out2_en  out  1  rf read enables
rf_out1 / rf_out2  in  16  rf read data (combinational from rf)
w_data  out  16 / w_addr  out  4 / w_en  out  1  rf GPR write
pc_data  out  16 / pc_addr  out  4 / pc_en  out  1  rf PC write
halted  out  1  core stopped
illegal  out  1  sticky illegal-instruction flag

Behaviour:
- ISA: ir[15:12]=op, ir[11:8]=rd, ir[7:4]=rs1, ir[3:0]=rs2/imm4.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL (by b[3:0]), 7 SHR logical (by b[3:0]).
  - 8 ADDI: rs2 field is imm4, sign-extended.
  - 9 BEQZ: test reg = ir[11:8], offset = ir[7:0] signed.
  - A JR: target reg = ir[11:8].
  - F HALT.
  - B–E illegal.
- All arithmetic is mod 2^16; no flags.
- Reset (async): state=IDLE, pc_q=RESET_PC, ir=0, all outputs 0 (halted=0, illegal=0).
- Outside their own states, all enables are 0 and all addresses/data are 0.
- IDLE: wait for run_en=1, then go to FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc_q.
  - imem_ack sampled every FETCH cycle, including the first. On ack: ir<=imem_rdata, go to DECODE. Otherwise stay in FETCH with req/addr stable.
- DECODE:
  - For ALU ops: out1_en=1, out1_addr=rs1; out2_en=1, out2_addr=rs2.
  - For BEQZ/JR: out1_en=1, out1_addr=ir[11:8]; out2_en=0.
  - a_q<=rf_out1, b_q<=rf_out2 (or sext(imm4) for ADDI). Go to EXEC.
- EXEC: compute res_q and next_pc.
  - Default next_pc = pc_q+1.
  - BEQZ: next_pc = pc_q+1+sext(off8) if a_q==0.
  - JR: next_pc = a_q.
  - Transitions: ALU op with rd!=PC_REG -> WB. NOP/BEQZ/JR -> PCUP. HALT -> HALTED with pc_q unchanged.
  - Illegal opcode, or ALU op with rd==PC_REG: illegal<=1, no GPR write, go to PCUP.
- WB: w_en=1, w_addr=rd, w_data=res_q. Go to PCUP.
  - WB and PCUP are separate cycles because the rf accepts only one write per cycle (PC has priority).
- PCUP: pc_en=1, pc_addr=PC_REG, pc_data=next_pc; pc_q<=next_pc. Go to FETCH.
  - run_en is ignored after IDLE.
- HALTED: halted=1; stay there until rst.
- Latency with zero-wait ack: ALU op = 5 cycles (FETCH, DECODE, EXEC, WB, PCUP); branch/NOP = 4 cycles.
- PC wraps: 16'hFFFF+1 = 16'h0000.
- Reset mid-operation (any state, including a FETCH awaiting ack or WB): immediate return to IDLE. A pending fetch is abandoned, and a late ack in IDLE is ignored.

Decomposition:
- cpu_pkg:
  - opcode_e enum (4-bit).
  - state_e enum: IDLE, FETCH, DECODE, EXEC, WB, PCUP, HALTED.
  - field-slice constants.
  - PC_REG default.
- One sub-module alu16: combinational (op, a, b) -> result, covering ops 1–8; instantiated in ctrl_seq.

Test Plan:
1. Reset, pc_q=0, run_en=1, ack same cycle, imem[0]=16'h1312 (ADD r3=r1+r2), rf r1=5, r2=7 -> w_en=1, w_addr=3, w_data=12 in cycle 4; pc_en=1, pc_data=1 in cycle 5.
2. BEQZ 16'h9405 at pc=0x10, r4=0 -> pc_data=0x16. With r4=1 -> pc_data=0x11. w_en never asserts.
3. Ack delayed 3 cycles -> imem_req=1 and imem_addr stable for 4 FETCH cycles, then DECODE. Total ALU latency 8 cycles.
4. Opcode 16'hB000 -> illegal=1 (sticky), no w_en, pc advances by 1. ADD with rd=15 gives the same response.
5. pc=0xFFFF executing NOP -> pc_data=0x0000. Next instruction is HALT -> halted=1 persists, no further imem_req.
6. Assert rst during WB -> w_en drops to 0 the same cycle, all outputs 0, pc_q=RESET_PC. A stale ack after release does not advance the sequencer until run_en is asserted.
